// File: rtl/ic_tag_ecc_wr_arb_if.sv
// Tag-write arbiter bus: init control, refill/fix requesters, external ECC encoder and tag RAM write port.
interface ic_tag_ecc_wr_arb_if;
  logic        init_start;
  logic        init_busy;
  logic        refill_req;
  logic [7:0]  refill_addr;
  logic [20:0] refill_tag;
  logic        refill_ack;
  logic        fix_req;
  logic [7:0]  fix_addr;
  logic [20:0] fix_tag;
  logic        fix_ack;
  logic [20:0] enc_data;
  logic [7:0]  enc_addr;
  logic [6:0]  enc_ecc;
  logic        tag_we;
  logic [7:0]  tag_waddr;
  logic [27:0] tag_wdata;

  modport slave (
    input  init_start, refill_req, refill_addr, refill_tag,
           fix_req, fix_addr, fix_tag, enc_ecc,
    output init_busy, refill_ack, fix_ack, enc_data, enc_addr,
           tag_we, tag_waddr, tag_wdata
  );

  modport master (
    output init_start, refill_req, refill_addr, refill_tag,
           fix_req, fix_addr, fix_tag, enc_ecc,
    input  init_busy, refill_ack, fix_ack, enc_data, enc_addr,
           tag_we, tag_waddr, tag_wdata
  );
endinterface

// File: rtl/ic_tag_ecc_wr_arb.sv
// Tag RAM write arbiter: init sweep after reset/init_start, then fix-over-refill priority,
// ECC encoded in the grant cycle and written one cycle later.
module ic_tag_ecc_wr_arb (
  input logic                   clk,
  input logic                   rst_a,
  ic_tag_ecc_wr_arb_if.slave    bus
);

  typedef enum logic {INIT, RUN} state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       grant;

  always_ff @(posedge clk) begin
    if (rst_a) begin
      state <= INIT;
      cnt   <= 8'h00;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    grant          = 1'b0;
    bus.fix_ack    = 1'b0;
    bus.refill_ack = 1'b0;
    bus.enc_data   = 21'h0;
    bus.enc_addr   = 8'h00;
    case (state)
      INIT: begin
        // init_start is deliberately not looked at here: a running sweep never restarts
        grant        = 1'b1;
        bus.enc_addr = cnt;
        cnt_nxt      = cnt + 8'h01;
        if (cnt == 8'hFF) state_nxt = RUN;
      end
      RUN: begin
        if (bus.fix_req) begin
          grant        = 1'b1;
          bus.fix_ack  = 1'b1;
          bus.enc_data = bus.fix_tag;
          bus.enc_addr = bus.fix_addr;
        end else if (bus.refill_req) begin
          grant          = 1'b1;
          bus.refill_ack = 1'b1;
          bus.enc_data   = bus.refill_tag;
          bus.enc_addr   = bus.refill_addr;
        end
        if (bus.init_start) begin
          state_nxt = INIT;
          cnt_nxt   = 8'h00;
        end
      end
      default: state_nxt = INIT;
    endcase
    // a grant taken during reset would be lost anyway, so never report it
    if (rst_a) begin
      grant          = 1'b0;
      bus.fix_ack    = 1'b0;
      bus.refill_ack = 1'b0;
    end
  end

  assign bus.init_busy = (state == INIT);

  always_ff @(posedge clk) begin
    if (rst_a) begin
      bus.tag_we    <= 1'b0;
      bus.tag_waddr <= 8'h00;
      bus.tag_wdata <= 28'h0;
    end else begin
      bus.tag_we <= grant;
      if (grant) begin
        bus.tag_waddr <= bus.enc_addr;
        bus.tag_wdata <= {bus.enc_ecc, bus.enc_data};
      end
    end
  end

endmodule

// File: tb/tb_ic_tag_ecc_wr_arb.sv
// Bench for ic_tag_ecc_wr_arb: cycle model of grants/writes, vector table, corner sequences, random traffic.
module tb_ic_tag_ecc_wr_arb;

  logic clk = 1'b0;
  logic rst_a;
  always #5 clk = ~clk;

  ic_tag_ecc_wr_arb_if bus();
  ic_tag_ecc_wr_arb dut (.clk(clk), .rst_a(rst_a), .bus(bus));

  function automatic logic [6:0] ecc_model(input logic [20:0] t, input logic [7:0] a);
    logic [28:0] v, m;
    logic [6:0]  e;
    v = {a, t};
    for (int i = 0; i < 7; i++) begin
      m    = (29'h15A3C96B << (i * 3)) ^ (29'h0F0F0F0F >> i);
      e[i] = ^(v & m);
    end
    return e;
  endfunction

  assign bus.enc_ecc = ecc_model(bus.enc_data, bus.enc_addr);

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: sweep position, write expected this cycle
  bit          m_valid = 0, m_sweep = 0, m_pv = 0, m_zero = 0;
  int          m_idx = 0;
  logic [7:0]  m_pa;
  logic [27:0] m_pd;

  // values sampled during the last cycle
  logic        o_fix, o_ref, o_busy, o_we;
  logic [7:0]  o_waddr, o_encaddr;
  logic [27:0] o_wdata;

  task automatic cycle(input logic r, input logic s, input logic fq, input logic rq,
                       input logic [7:0] fa, input logic [7:0] ra,
                       input logic [20:0] ft, input logic [20:0] rt);
    logic        g, ef, er;
    logic [7:0]  ga;
    logic [20:0] gt;
    rst_a = r; bus.init_start = s;
    bus.fix_req = fq; bus.fix_addr = fa; bus.fix_tag = ft;
    bus.refill_req = rq; bus.refill_addr = ra; bus.refill_tag = rt;
    #2;
    o_fix = bus.fix_ack; o_ref = bus.refill_ack; o_busy = bus.init_busy;
    o_we = bus.tag_we; o_waddr = bus.tag_waddr; o_wdata = bus.tag_wdata;
    o_encaddr = bus.enc_addr;
    ef = !r && m_valid && !m_sweep && fq;
    er = !r && m_valid && !m_sweep && rq && !fq;
    chk("fix_ack", {31'b0, o_fix}, {31'b0, ef});
    chk("refill_ack", {31'b0, o_ref}, {31'b0, er});
    g = 0; ga = 0; gt = 0;
    if (!r && m_valid) begin
      if (m_sweep) begin g = 1; ga = m_idx[7:0]; gt = 0; end
      else if (fq)  begin g = 1; ga = fa; gt = ft; end
      else if (rq)  begin g = 1; ga = ra; gt = rt; end
      chk("enc_addr", {24'b0, bus.enc_addr}, {24'b0, ga});
      chk("enc_data", {11'b0, bus.enc_data}, {11'b0, gt});
    end
    if (m_valid) begin
      chk("init_busy", {31'b0, o_busy}, {31'b0, m_sweep});
      chk("tag_we", {31'b0, o_we}, {31'b0, m_pv});
      if (m_pv) begin
        chk("tag_waddr", {24'b0, o_waddr}, {24'b0, m_pa});
        chk("tag_wdata", {4'b0, o_wdata}, {4'b0, m_pd});
      end
      if (m_zero) begin
        chk("rst_waddr", {24'b0, o_waddr}, 32'h0);
        chk("rst_wdata", {4'b0, o_wdata}, 32'h0);
      end
    end
    if (r) begin
      m_valid = 1; m_sweep = 1; m_idx = 0; m_pv = 0; m_zero = 1;
    end else begin
      m_zero = 0;
      m_pv   = g;
      if (g) begin m_pa = ga; m_pd = {ecc_model(gt, ga), gt}; end
      if (m_sweep) begin
        if (m_idx == 255) m_sweep = 0;
        m_idx++;
      end else if (s) begin
        m_sweep = 1; m_idx = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 8'h0, 8'h0, 21'h0, 21'h0);
  endtask

  typedef struct {
    logic        fq, rq;
    logic [7:0]  fa, ra;
    logic [20:0] ft, rt;
    logic        ef, er, ewe;
    logic [7:0]  ewa;
    logic [20:0] ewt;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int          k, nwr, max_fw, fw, acks;
    bit          fp, rp;
    logic [7:0]  fa, ra;
    logic [20:0] ft, rt;

    tbl[0] = '{1, 1, 8'h34, 8'h12, 21'h1FFFFF, 21'h0ABCDE, 1, 0, 0, 8'h00, 21'h0};
    tbl[1] = '{0, 1, 8'h00, 8'h12, 21'h0,      21'h0ABCDE, 0, 1, 1, 8'h34, 21'h1FFFFF};
    tbl[2] = '{0, 0, 8'h00, 8'h00, 21'h0,      21'h0,      0, 0, 1, 8'h12, 21'h0ABCDE};
    tbl[3] = '{0, 0, 8'h00, 8'h00, 21'h0,      21'h0,      0, 0, 0, 8'h00, 21'h0};
    tbl[4] = '{0, 1, 8'h00, 8'hFF, 21'h0,      21'h1FFFFF, 0, 1, 0, 8'h00, 21'h0};
    tbl[5] = '{0, 0, 8'h00, 8'h00, 21'h0,      21'h0,      0, 0, 1, 8'hFF, 21'h1FFFFF};
    tbl[6] = '{1, 0, 8'h00, 8'h00, 21'h0,      21'h0,      1, 0, 0, 8'h00, 21'h0};
    tbl[7] = '{1, 1, 8'h01, 8'h99, 21'h000001, 21'h0F0F0F, 1, 0, 1, 8'h00, 21'h0};
    tbl[8] = '{0, 1, 8'h00, 8'h99, 21'h0,      21'h0F0F0F, 0, 1, 1, 8'h01, 21'h000001};
    tbl[9] = '{0, 0, 8'h00, 8'h00, 21'h0,      21'h0,      0, 0, 1, 8'h99, 21'h0F0F0F};

    @(posedge clk); #1;

    // reset with refill held, then the full sweep and the first refill grant
    cycle(1, 0, 0, 1, 8'h0, 8'h55, 21'h0, 21'h12345);
    cycle(1, 0, 0, 1, 8'h0, 8'h55, 21'h0, 21'h12345);
    chk("rst_busy", {31'b0, o_busy}, 32'h1);
    chk("rst_we", {31'b0, o_we}, 32'h0);
    k = 0; nwr = 0;
    while (k < 300) begin
      cycle(0, 0, 0, 1, 8'h0, 8'h55, 21'h0, 21'h12345);
      if (o_we) nwr++;
      if (o_ref) break;
      k++;
    end
    chk("first_refill_ack_cycle", k, 256);
    chk("sweep_writes", nwr, 256);
    idle(2);

    // vector table in RUN
    foreach (tbl[i]) begin
      cycle(0, 0, tbl[i].fq, tbl[i].rq, tbl[i].fa, tbl[i].ra, tbl[i].ft, tbl[i].rt);
      chk($sformatf("tbl%0d_fix_ack", i), {31'b0, o_fix}, {31'b0, tbl[i].ef});
      chk($sformatf("tbl%0d_refill_ack", i), {31'b0, o_ref}, {31'b0, tbl[i].er});
      chk($sformatf("tbl%0d_we", i), {31'b0, o_we}, {31'b0, tbl[i].ewe});
      if (tbl[i].ewe) begin
        chk($sformatf("tbl%0d_waddr", i), {24'b0, o_waddr}, {24'b0, tbl[i].ewa});
        chk($sformatf("tbl%0d_wdata", i), {4'b0, o_wdata},
            {4'b0, ecc_model(tbl[i].ewt, tbl[i].ewa), tbl[i].ewt});
      end
    end

    // init_start mid-sweep is ignored
    cycle(1, 0, 0, 0, 8'h0, 8'h0, 21'h0, 21'h0);
    k = 0;
    while (k < 600) begin
      cycle(0, (k == 8'h80), 0, 0, 8'h0, 8'h0, 21'h0, 21'h0);
      if (!o_busy) break;
      k++;
    end
    chk("busy_len_with_init_pulse", k, 256);

    // init_start in RUN alongside a fix grant
    cycle(0, 1, 1, 0, 8'h77, 8'h0, 21'h155555, 21'h0);
    chk("fix_with_init_ack", {31'b0, o_fix}, 32'h1);
    idle(1);
    chk("fix_with_init_we", {31'b0, o_we}, 32'h1);
    chk("fix_with_init_waddr", {24'b0, o_waddr}, 32'h77);
    chk("new_sweep_busy", {31'b0, o_busy}, 32'h1);
    chk("new_sweep_idx0", {24'b0, o_encaddr}, 32'h0);
    idle(1);
    chk("new_sweep_idx1", {24'b0, o_encaddr}, 32'h1);
    idle(256);

    // reset pulse mid-sweep restarts at index 0
    cycle(1, 0, 0, 0, 8'h0, 8'h0, 21'h0, 21'h0);
    idle(8'h40);
    cycle(1, 0, 1, 1, 8'h3, 8'h4, 21'h5, 21'h6);
    idle(1);
    chk("midrst_we", {31'b0, o_we}, 32'h0);
    chk("midrst_waddr", {24'b0, o_waddr}, 32'h0);
    chk("midrst_wdata", {4'b0, o_wdata}, 32'h0);
    chk("midrst_busy", {31'b0, o_busy}, 32'h1);
    chk("midrst_idx0", {24'b0, o_encaddr}, 32'h0);
    idle(1);
    chk("midrst_first_we", {31'b0, o_we}, 32'h1);
    chk("midrst_first_waddr", {24'b0, o_waddr}, 32'h0);
    idle(256);

    // random RUN traffic; requesters hold until acked
    fp = 0; rp = 0; fa = 0; ra = 0; ft = 0; rt = 0;
    acks = 0; fw = 0; max_fw = 0; k = 0;
    while (acks < 10000 && k < 40000) begin
      if (!fp && ($urandom % 4 == 0)) begin
        fp = 1; fa = 8'($urandom); ft = 21'($urandom);
      end
      if (!rp && ($urandom % 2 == 0)) begin
        rp = 1; ra = 8'($urandom); rt = 21'($urandom);
      end
      cycle(0, ($urandom % 3000 == 0), fp, rp, fa, ra, ft, rt);
      if (fp) fw++;
      if (o_fix) begin
        fp = 0; acks++;
        if (fw > max_fw) max_fw = fw;
        fw = 0;
      end
      if (o_ref) begin rp = 0; acks++; end
      k++;
    end
    chk("random_acks_done", {31'b0, acks >= 10000}, 32'h1);
    chk("fix_no_starvation", {31'b0, max_fw <= 257}, 32'h1);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ic_tag_ecc_wr_arb.md
IC_TAG_ECC_WR_ARB -- requirements
Module: ic_tag_ecc_wr_arb

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at tag 21 b, index 8 b, ECC 7 b.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_a  in  1  reset, synchronous and active-high.
REQ-004 init_start  in  1  single-cycle pulse requesting a full tag-array initialisation sweep.
REQ-005 init_busy  out  1  high while the init sweep is in progress.
REQ-006 refill_req / refill_addr / refill_tag  in  1/8/21  refill tag-write request, index, tag value.
REQ-007 refill_ack  out  1  refill request granted this cycle.
REQ-008 fix_req / fix_addr / fix_tag  in  1/8/21  ECC-correction writeback request, index, corrected tag.
REQ-009 fix_ack  out  1  fix request granted this cycle.
REQ-010 enc_data / enc_addr  out  21/8  operands driven to the external combinational tag ECC encoder.
REQ-011 enc_ecc  in  7  encoder result for the current enc_data/enc_addr, same cycle.
REQ-012 tag_we / tag_waddr / tag_wdata  out  1/8/28  tag RAM write port; tag_wdata = {ecc[6:0], tag[20:0]}.

Function
REQ-013 The FSM SHALL have exactly two states: INIT and RUN.
REQ-014 In INIT, an 8-bit sweep counter SHALL index sets 0..255, with one grant per cycle, enc_data = 21'h0 and enc_addr = counter.
REQ-015 INIT SHALL leave RUN-state grants inactive: refill_ack = fix_ack = 0 regardless of requests.
REQ-016 When counter = 255 is granted, the next state SHALL be RUN; the counter SHALL NOT wrap back into another sweep.
REQ-017 In RUN, fix_req SHALL win over refill_req; when both are high, only fix_ack asserts and refill waits.
REQ-018 A granted requester SHALL see its ack high for exactly the grant cycle; enc_data/enc_addr SHALL equal that requester's tag/addr in the same cycle.
REQ-019 Requesters SHALL hold req/addr/tag stable until ack; the block SHALL NOT latch unacked requests.
REQ-020 With no grant in RUN, enc_data/enc_addr SHALL be 0 and no write SHALL be issued the following cycle.
REQ-021 On every grant cycle, the block SHALL register {enc_ecc, enc_data} and enc_addr; the next cycle, tag_we = 1 with those values, a fixed latency of 1.
REQ-022 tag_we SHALL be high for one cycle per grant; back-to-back grants SHALL produce back-to-back writes, up to 1 write/cycle.
REQ-023 init_start in RUN SHALL enter INIT with counter = 0 in the next cycle; any RUN grant in that same cycle still completes its write.
REQ-024 init_start during INIT SHALL be ignored, with no counter restart.
REQ-025 init_busy SHALL equal (state == INIT).

Reset
REQ-026 On rst_a high at a clock edge, the block SHALL set state = INIT, counter = 0, tag_we = 0, tag_waddr = 0 and tag_wdata = 0; refill_ack and fix_ack SHALL be 0 in the cycle rst_a is high.
REQ-027 The init sweep SHALL start automatically in the first cycle after rst_a deasserts.
REQ-028 rst_a asserted mid-sweep or mid-write SHALL abandon any pending write (tag_we = 0 next cycle) and restart the sweep from index 0.

Verification
REQ-029 Release reset with refill_req held high -> tag_we on 256 consecutive cycles, tag_waddr 0x00..0xFF, tag_wdata[20:0] = 0, each ECC matching the encoder model; refill_ack first rises in the cycle after the index-0xFF grant.
REQ-030 In RUN, refill_req = fix_req = 1 with addr 0x12/0x34 and tags 0x0ABCDE/0x1FFFFF -> fix_ack in cycle N and write 0x34 in N+1; refill_ack in N+1 and write 0x12 in N+2.
REQ-031 Single refill, addr 0xFF, tag 0x1FFFFF -> one tag_we pulse one cycle after ack, tag_wdata = {model_ecc(0x1FFFFF, 0xFF), 0x1FFFFF}.
REQ-032 init_start pulsed at sweep index 0x80, then again in RUN together with a fix grant -> first pulse has no effect (sweep ends at 0xFF); second pulse lets the fix write complete, then a new sweep starts at 0x00 with init_busy = 1.
REQ-033 rst_a pulsed for one cycle at sweep index 0x40 -> tag_we = 0 the cycle after, then the sweep restarts at 0x00 and all outputs hold their reset values while rst_a is high.
REQ-034 Random RUN traffic of 10k requests against a scoreboard -> every ack matched by exactly one write one cycle later, no fix starvation, and refill is granted whenever fix_req = 0.
